global_timestamp_sched: RTL and testbench



---
 rtl/gts_pkg.sv | 19 +
 rtl/gts_max_tree.sv | 78 +++++++
 rtl/global_timestamp_sched.sv | 189 ++++++++++++++++++
 tb/tb_global_timestamp_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gts_pkg.sv
// Shared types for the global timestamp scheduler.
//   TS_WIDTH_DEFAULT : default timestamp width in bits
//   ts_t             : timestamp of the default width
//   gts_state_e      : scheduler round states
package gts_pkg;

  localparam int TS_WIDTH_DEFAULT = 53;

  typedef logic [TS_WIDTH_DEFAULT-1:0] ts_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    COMPUTE,
    BCAST
  } gts_state_e;

endpackage

// File: rtl/gts_max_tree.sv
// Masked max (and optionally min) reduction over the per-port captured
// timestamps, built as a balanced pairwise tree. Ports whose mask bit is
// clear contribute 0 to the max and are excluded from the min.
// Optional feature macro: GTS_SPREAD_STATS_EN adds the min output.
// Ports:
//   ts     in  NUM_PORTS*TS_WIDTH  packed timestamps, port i at [i*TS_WIDTH +: TS_WIDTH]
//   mask   in  NUM_PORTS           ports taking part in the reduction
//   min_ts out TS_WIDTH            min over masked ports, 0 if none (macro only)
//   max_ts out TS_WIDTH            max over masked ports, 0 if none
module gts_max_tree
  import gts_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int TS_WIDTH  = TS_WIDTH_DEFAULT
) (
  input  logic [NUM_PORTS*TS_WIDTH-1:0] ts,
  input  logic [NUM_PORTS-1:0]          mask,
`ifdef GTS_SPREAD_STATS_EN
  output logic [TS_WIDTH-1:0]           min_ts,
`endif
  output logic [TS_WIDTH-1:0]           max_ts
);

  // Leaves are padded to a power of two; padded leaves are always masked off.
  localparam int LEAVES = 1 << $clog2(NUM_PORTS);
  localparam int NODES  = 2 * LEAVES - 1;

  logic [LEAVES*TS_WIDTH-1:0] ts_pad;
  logic [LEAVES-1:0]          mask_pad;
  logic [TS_WIDTH-1:0]        mx [NODES];

  assign ts_pad   = (LEAVES*TS_WIDTH)'(ts);
  assign mask_pad = LEAVES'(mask);

  // Heap layout: node n has children 2n+1 and 2n+2; leaves start at LEAVES-1.
  always_comb begin
    for (int n = 0; n < NODES; n++) mx[n] = '0;
    for (int j = 0; j < LEAVES; j++) begin
      if (mask_pad[j]) mx[LEAVES-1+j] = ts_pad[j*TS_WIDTH +: TS_WIDTH];
    end
    for (int n = LEAVES - 2; n >= 0; n--) begin
      mx[n] = (mx[2*n+1] >= mx[2*n+2]) ? mx[2*n+1] : mx[2*n+2];
    end
  end

  assign max_ts = mx[0];

`ifdef GTS_SPREAD_STATS_EN
  logic [TS_WIDTH-1:0] mn [NODES];
  logic [NODES-1:0]    nv;

  // Min needs a per-node valid so masked ports never win with their 0.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      mn[n] = '0;
      nv[n] = 1'b0;
    end
    for (int j = 0; j < LEAVES; j++) begin
      if (mask_pad[j]) begin
        mn[LEAVES-1+j] = ts_pad[j*TS_WIDTH +: TS_WIDTH];
        nv[LEAVES-1+j] = 1'b1;
      end
    end
    for (int n = LEAVES - 2; n >= 0; n--) begin
      nv[n] = nv[2*n+1] | nv[2*n+2];
      if (nv[2*n+1] && nv[2*n+2])
        mn[n] = (mn[2*n+1] <= mn[2*n+2]) ? mn[2*n+1] : mn[2*n+2];
      else if (nv[2*n+1])
        mn[n] = mn[2*n+1];
      else
        mn[n] = mn[2*n+2];
    end
  end

  assign min_ts = mn[0];
`endif

endmodule

// File: rtl/global_timestamp_sched.sv
// Periodic global timestamp scheduler. Every SYNC_PERIOD cycles it requests a
// snapshot from each participating port, collects acknowledged timestamps
// (bounded by TIMEOUT cycles), reduces them to a maximum and broadcasts a
// monotonic global timestamp with a one-cycle sync_valid pulse.
// Optional feature macro: GTS_SPREAD_STATS_EN adds sync_spread / max_spread.
// Ports:
//   clock, reset   clock and synchronous active-high reset
//   enable         scheduler enable; dropping it aborts any round
//   port_mask      ports participating, latched at round start
//   snap_req       per-port snapshot request (level)
//   snap_ack       per-port one-cycle ack, snap_ts valid alongside
//   snap_ts        packed per-port timestamps
//   sync_valid     one-cycle pulse with a new global value
//   sync_ts        global timestamp, held between pulses
//   sync_ports     ports that contributed to the last broadcast
//   timeout_ports  ports that did not ack in the last round
//   round_overrun  sticky: period tick arrived while a round was busy
//   clear_status   clears round_overrun (and max_spread)
//   sync_spread    round max - round min over contributors (macro only)
//   max_spread     sticky maximum of sync_spread (macro only)
module global_timestamp_sched
  import gts_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int TS_WIDTH    = TS_WIDTH_DEFAULT,
  parameter int SYNC_PERIOD = 1024,
  parameter int TIMEOUT     = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_PORTS-1:0]          port_mask,
  output logic [NUM_PORTS-1:0]          snap_req,
  input  logic [NUM_PORTS-1:0]          snap_ack,
  input  logic [NUM_PORTS*TS_WIDTH-1:0] snap_ts,
  output logic                          sync_valid,
  output logic [TS_WIDTH-1:0]           sync_ts,
  output logic [NUM_PORTS-1:0]          sync_ports,
  output logic [NUM_PORTS-1:0]          timeout_ports,
  output logic                          round_overrun,
`ifdef GTS_SPREAD_STATS_EN
  output logic [TS_WIDTH-1:0]           sync_spread,
  output logic [TS_WIDTH-1:0]           max_spread,
`endif
  input  logic                          clear_status
);

  localparam int CNT_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(1);

  gts_state_e                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q;
  logic                          tick;
  logic [NUM_PORTS-1:0]          active_q;
  logic [NUM_PORTS-1:0]          collected_q;
  logic [NUM_PORTS-1:0]          acked;
  logic [NUM_PORTS-1:0]          collected_nxt;
  logic [TMO_W-1:0]              tmo_q;
  logic                          wait_done;
  logic [NUM_PORTS*TS_WIDTH-1:0] cap_ts_q;
  logic [TS_WIDTH-1:0]           round_max_p0;
`ifdef GTS_SPREAD_STATS_EN
  logic [TS_WIDTH-1:0]           round_min_p0;
  logic [TS_WIDTH-1:0]           spread_p0;
`endif

  assign tick          = enable && (cnt_q == CNT_LAST);
  // Only acks against an outstanding request count.
  assign acked         = snap_ack & snap_req;
  assign collected_nxt = collected_q | acked;
  // The last timeout cycle is the one where the counter steps 1 -> 0; an ack
  // in that cycle is still folded into collected_nxt.
  assign wait_done     = (collected_nxt == active_q) || (tmo_q == TMO_LAST);

  gts_max_tree #(
    .NUM_PORTS (NUM_PORTS),
    .TS_WIDTH  (TS_WIDTH)
  ) u_tree (
    .ts     (cap_ts_q),
    .mask   (collected_q),
`ifdef GTS_SPREAD_STATS_EN
    .min_ts (round_min_p0),
`endif
    .max_ts (round_max_p0)
  );

`ifdef GTS_SPREAD_STATS_EN
  assign spread_p0 = round_max_p0 - round_min_p0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick && (port_mask != '0)) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (wait_done) state_d = COMPUTE;
      COMPUTE: state_d = BCAST;
      BCAST:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Captured snapshots are plain data: no reset, masked by collected_q.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (acked[i]) cap_ts_q[i*TS_WIDTH +: TS_WIDTH] <= snap_ts[i*TS_WIDTH +: TS_WIDTH];
    end
  end

  // sync_ts doubles as the last-sync register that enforces monotonicity.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q         <= '0;
      active_q      <= '0;
      collected_q   <= '0;
      tmo_q         <= '0;
      snap_req      <= '0;
      sync_valid    <= 1'b0;
      sync_ts       <= '0;
      sync_ports    <= '0;
      timeout_ports <= '0;
      round_overrun <= 1'b0;
`ifdef GTS_SPREAD_STATS_EN
      sync_spread   <= '0;
      max_spread    <= '0;
`endif
    end else begin
      sync_valid <= 1'b0;

      if (!enable || (cnt_q == CNT_LAST)) cnt_q <= '0;
      else                                cnt_q <= cnt_q + 1'b1;

      if (tick && (state_q != IDLE)) round_overrun <= 1'b1;
      else if (clear_status)         round_overrun <= 1'b0;

      if (!enable) begin
        snap_req <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (tick && (port_mask != '0)) begin
              active_q <= port_mask;
              snap_req <= port_mask;
            end
          end
          REQ: begin
            collected_q <= acked;
            tmo_q       <= TMO_LOAD;
            snap_req    <= snap_req & ~acked;
          end
          WAIT: begin
            collected_q <= collected_nxt;
            tmo_q       <= tmo_q - 1'b1;
            snap_req    <= wait_done ? '0 : (snap_req & ~acked);
          end
          // ---- COMPUTE -> BCAST stage boundary: tree output registered here
          COMPUTE: begin
            timeout_ports <= active_q & ~collected_q;
            if (collected_q != '0) begin
              sync_valid <= 1'b1;
              sync_ports <= collected_q;
              if (round_max_p0 > sync_ts) sync_ts <= round_max_p0;
            end
          end
          default: ;
        endcase
      end

`ifdef GTS_SPREAD_STATS_EN
      if (enable && (state_q == COMPUTE) && (collected_q != '0)) begin
        sync_spread <= spread_p0;
        max_spread  <= (clear_status || (spread_p0 > max_spread)) ? spread_p0 : max_spread;
      end else if (clear_status) begin
        max_spread  <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_global_timestamp_sched.sv
module tb_global_timestamp_sched;

  localparam int NP     = 4;
  localparam int TW     = 53;
  localparam int SP     = 16;
  localparam int TO     = 8;
  localparam int WINDOW = 13;
  localparam int NEV    = 31;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset, enable, clear_status;
  logic [NP-1:0]    port_mask, snap_req, snap_ack, sync_ports, timeout_ports;
  logic [NP*TW-1:0] snap_ts;
  logic             sync_valid, round_overrun;
  logic [TW-1:0]    sync_ts;

  logic             ovr_enable, ovr_clear, ovr_valid, ovr_overrun;
  logic [NP-1:0]    ovr_mask, ovr_req, ovr_ack, ovr_ports, ovr_tmo_ports;
  logic [NP*TW-1:0] ovr_ts_bus;
  logic [TW-1:0]    ovr_sync_ts;
`ifdef GTS_SPREAD_STATS_EN
  logic [TW-1:0]    sync_spread, max_spread, ovr_spread, ovr_max_spread;
`endif

  global_timestamp_sched #(
    .NUM_PORTS(NP), .TS_WIDTH(TW), .SYNC_PERIOD(SP), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .port_mask(port_mask),
    .snap_req(snap_req), .snap_ack(snap_ack), .snap_ts(snap_ts),
    .sync_valid(sync_valid), .sync_ts(sync_ts), .sync_ports(sync_ports),
    .timeout_ports(timeout_ports), .round_overrun(round_overrun),
`ifdef GTS_SPREAD_STATS_EN
    .sync_spread(sync_spread), .max_spread(max_spread),
`endif
    .clear_status(clear_status)
  );

  // Second instance with a timeout longer than the period to provoke overrun.
  global_timestamp_sched #(
    .NUM_PORTS(NP), .TS_WIDTH(TW), .SYNC_PERIOD(SP), .TIMEOUT(20)
  ) dut_ovr (
    .clock(clock), .reset(reset), .enable(ovr_enable), .port_mask(ovr_mask),
    .snap_req(ovr_req), .snap_ack(ovr_ack), .snap_ts(ovr_ts_bus),
    .sync_valid(ovr_valid), .sync_ts(ovr_sync_ts), .sync_ports(ovr_ports),
    .timeout_ports(ovr_tmo_ports), .round_overrun(ovr_overrun),
`ifdef GTS_SPREAD_STATS_EN
    .sync_spread(ovr_spread), .max_spread(ovr_max_spread),
`endif
    .clear_status(ovr_clear)
  );

  typedef struct packed {
    logic [1:0]           idle;
    logic [3:0]           mask;
    logic [3:0][4:0]      dly;
    logic [3:0][TW-1:0]   ts;
    logic [TW-1:0]        exp_ts;
    logic [3:0]           exp_ports;
    logic [3:0]           exp_tmo;
    logic [4:0]           lat;
  } vec_t;

  vec_t vecs [8];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input int idle, input logic [3:0] mask,
                              input int d0, input int d1, input int d2, input int d3,
                              input longint t0, input longint t1, input longint t2, input longint t3,
                              input longint ets, input logic [3:0] ports, input logic [3:0] tmo,
                              input int lat);
    vec_t v;
    v.idle      = 2'(idle);
    v.mask      = mask;
    v.dly[0]    = 5'(d0);
    v.dly[1]    = 5'(d1);
    v.dly[2]    = 5'(d2);
    v.dly[3]    = 5'(d3);
    v.ts[0]     = TW'(t0);
    v.ts[1]     = TW'(t1);
    v.ts[2]     = TW'(t2);
    v.ts[3]     = TW'(t3);
    v.exp_ts    = TW'(ets);
    v.exp_ports = ports;
    v.exp_tmo   = tmo;
    v.lat       = 5'(lat);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while ((snap_req == '0) && (n < 40)) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_req_seen"}, 64'(snap_req != '0), 64'(1));
  endtask

  task automatic run_round(input int idx);
    vec_t  v;
    string tag;
    int    first_k;
    int    pulses;
    bit    quiet;
    logic [3:0] ack_v;
    v   = vecs[idx];
    tag = $sformatf("r%0d", idx);
    if (v.idle != 0) begin
      quiet     = 1'b1;
      port_mask = '0;
      repeat (int'(v.idle) * SP) begin
        @(negedge clock);
        if ((snap_req != '0) || sync_valid || round_overrun) quiet = 1'b0;
      end
      check({tag, "_idle_quiet"}, 64'(quiet), 64'(1));
    end
    port_mask = v.mask;
    for (int i = 0; i < NP; i++) snap_ts[i*TW +: TW] = v.ts[i];
    wait_req(tag);
    if (snap_req != '0) begin
      first_k = 0;
      pulses  = 0;
      for (int k = 1; k <= WINDOW; k++) begin
        @(negedge clock);
        if (sync_valid) begin
          pulses++;
          if (first_k == 0) first_k = k;
        end
        for (int i = 0; i < NP; i++) ack_v[i] = (int'(v.dly[i]) == k);
        snap_ack = ack_v;
      end
      snap_ack = '0;
      check({tag, "_latency"},  64'(first_k), 64'(v.lat));
      check({tag, "_pulses"},   64'(pulses), 64'((v.lat != 0) ? 1 : 0));
      check({tag, "_sync_ts"},  64'(sync_ts), 64'(v.exp_ts));
      check({tag, "_ports"},    64'(sync_ports), 64'(v.exp_ports));
      check({tag, "_timeouts"}, 64'(timeout_ports), 64'(v.exp_tmo));
      check({tag, "_req_idle"}, 64'(snap_req), 64'(0));
      check({tag, "_overrun"},  64'(round_overrun), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int first_k;
    int pulses;

    //        idle mask    delays           timestamps              exp  ports    tmo     lat
    vecs[0] = mk(0, 4'b1111, 1, 3, NEV, 2,  10, 20, 0, 30,          30, 4'b1011, 4'b0100, 10);
    vecs[1] = mk(0, 4'b1111, 2, 2, 2, 2,    100, 250, 75, 249,      250, 4'b1111, 4'b0000, 4);
    vecs[2] = mk(0, 4'b0110, NEV, 8, NEV, NEV, 0, 260, 0, 0,        260, 4'b0010, 4'b0100, 10);
    vecs[3] = mk(0, 4'b0001, 1, 1, NEV, NEV, 500, 999, 0, 0,        500, 4'b0001, 4'b0000, 3);
    vecs[4] = mk(0, 4'b0011, 2, 1, NEV, NEV, 400, 450, 0, 0,        500, 4'b0011, 4'b0000, 4);
    vecs[5] = mk(0, 4'b0100, NEV, NEV, NEV, NEV, 0, 0, 0, 0,        500, 4'b0011, 4'b0100, 0);
    vecs[6] = mk(3, 4'b0001, 2, NEV, NEV, NEV, 7, 0, 0, 0,          500, 4'b0001, 4'b0000, 4);
    vecs[7] = mk(0, 4'b0011, 1, 1, NEV, NEV, 5, 9, 0, 0,            9, 4'b0011, 4'b0000, 3);

    reset = 1'b1; enable = 1'b1; clear_status = 1'b0;
    port_mask = '0; snap_ack = '0; snap_ts = '0;
    ovr_enable = 1'b0; ovr_clear = 1'b0; ovr_mask = '0; ovr_ack = '0; ovr_ts_bus = '0;
    repeat (3) @(negedge clock);
    check("rst_req",      64'(snap_req), 64'(0));
    check("rst_valid",    64'(sync_valid), 64'(0));
    check("rst_ts",       64'(sync_ts), 64'(0));
    check("rst_ports",    64'(sync_ports), 64'(0));
    check("rst_timeouts", 64'(timeout_ports), 64'(0));
    check("rst_overrun",  64'(round_overrun), 64'(0));
    reset = 1'b0;

    for (int r = 0; r < 7; r++) run_round(r);

    // Enable dropped mid-WAIT: request falls, no broadcast, outputs hold.
    port_mask = 4'b0001;
    wait_req("en");
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    check("en_drop_req", 64'(snap_req), 64'(0));
    pulses = 0;
    repeat (12) begin
      @(negedge clock);
      if (sync_valid) pulses++;
    end
    check("en_drop_pulses", 64'(pulses), 64'(0));
    check("en_drop_ts",     64'(sync_ts), 64'(500));
    check("en_drop_ports",  64'(sync_ports), 64'(4'b0001));
    enable = 1'b1;

    // Reset mid-WAIT, then the next round starts one full period later.
    port_mask = 4'b0011;
    wait_req("rst2");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst2_req",      64'(snap_req), 64'(0));
    check("rst2_valid",    64'(sync_valid), 64'(0));
    check("rst2_ts",       64'(sync_ts), 64'(0));
    check("rst2_ports",    64'(sync_ports), 64'(0));
    check("rst2_timeouts", 64'(timeout_ports), 64'(0));
    check("rst2_overrun",  64'(round_overrun), 64'(0));
    reset = 1'b0;
    n = 0;
    while ((snap_req == '0) && (n < 40)) begin
      @(negedge clock);
      n++;
    end
    check("rst2_restart_cycles", 64'(n), 64'(16));
    run_round(7);

    // Overrun: acks held off past the next tick on the long-timeout instance.
    ovr_mask = 4'b0011;
    ovr_ts_bus[0*TW +: TW] = TW'(100);
    ovr_ts_bus[1*TW +: TW] = TW'(130);
    ovr_enable = 1'b1;
    n = 0;
    while ((ovr_req == '0) && (n < 40)) begin
      @(negedge clock);
      n++;
    end
    check("ovr_req_seen", 64'(ovr_req != '0), 64'(1));
    first_k = 0;
    pulses  = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clock);
      if (k == 15) check("ovr_before_tick", 64'(ovr_overrun), 64'(0));
      if (k == 16) check("ovr_set", 64'(ovr_overrun), 64'(1));
      if (k == 21) check("ovr_sticky", 64'(ovr_overrun), 64'(1));
      if (k == 23) check("ovr_cleared", 64'(ovr_overrun), 64'(0));
      if (ovr_valid) begin
        pulses++;
        if (first_k == 0) begin
          first_k = k;
`ifdef GTS_SPREAD_STATS_EN
          check("ovr_sync_spread", 64'(ovr_spread), 64'(30));
          check("ovr_max_spread",  64'(ovr_max_spread), 64'(30));
`endif
        end
      end
`ifdef GTS_SPREAD_STATS_EN
      if (k == 23) check("ovr_max_spread_clr", 64'(ovr_max_spread), 64'(0));
`endif
      ovr_ack   = (k == 17) ? 4'b0011 : 4'b0000;
      ovr_clear = (k == 22);
    end
    ovr_ack = '0;
    ovr_clear = 1'b0;
    ovr_enable = 1'b0;
    check("ovr_latency",  64'(first_k), 64'(19));
    check("ovr_pulses",   64'(pulses), 64'(1));
    check("ovr_sync_ts",  64'(ovr_sync_ts), 64'(130));
    check("ovr_ports",    64'(ovr_ports), 64'(4'b0011));
    check("ovr_timeouts", 64'(ovr_tmo_ports), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
